period_meter: RTL and testbench

Measures the period and high time of a slow single-bit signal, expressed in cycles of the system clock. It sits directly downstream of `freq_div`: any of `CLK_50`, `CLK_10` or `CLK_1` (or another divided/external strobe) is routed to `SIG_in`. This lets the divider's ratios and duty cycle be checked in-circuit. The result is reported through a one-shot or continuous measurement with a `VALID` pulse.

---
 rtl/period_meter.sv | 154 +++++++++++++++
 tb/tb_period_meter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the period and high time of a slow, possibly asynchronous signal in
// system-clock cycles. Supports one-shot and continuous measurement.
module period_meter #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK_in,
  input  logic         RST,
  input  logic         SIG_in,
  input  logic         START,
  input  logic         CONT,
  output logic [W-1:0] PERIOD,
  output logic [W-1:0] HIGH_TIME,
  output logic         VALID,
  output logic         BUSY,
  output logic         OVF
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX   = {W{1'b1}};
  localparam logic [W-1:0] LIMIT = {{(W-1){1'b1}}, 1'b0};

  state_t                 state_q, state_d;
  logic [W-1:0]           cnt_q, cnt_d;
  logic [W-1:0]           shadow_q, shadow_d;
  logic                   hseen_q, hseen_d;
  logic [W-1:0]           period_q, period_d;
  logic [W-1:0]           high_q, high_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_q, d_d;
  logic [SYNC_STAGES:0]   warm_q, warm_d;

  logic s_last;
  logic rise;
  logic fall;
  logic warm;
  logic [W-1:0] cnt_inc;

  assign s_last  = sync_q[SYNC_STAGES-1];
  assign rise    = s_last & ~d_q;
  assign fall    = ~s_last & d_q;
  // START stays blocked until the synchronizer and edge flop hold real samples.
  assign warm    = warm_q[SYNC_STAGES];
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hseen_d  = hseen_q;
    period_d = period_q;
    high_d   = high_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    sync_d   = {sync_q[SYNC_STAGES-2:0], SIG_in};
    d_d      = s_last;
    warm_d   = {warm_q[SYNC_STAGES-1:0], 1'b1};

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (START && warm) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          cnt_d   = '0;
          hseen_d = 1'b0;
          state_d = MEAS;
        end else if (cnt_q == LIMIT) begin
          period_d = '0;
          high_d   = '0;
          ovf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEAS: begin
        cnt_d = cnt_inc;
        if (fall) begin
          shadow_d = cnt_inc;
          hseen_d  = 1'b1;
        end
        if (rise) begin
          period_d = cnt_inc;
          high_d   = shadow_q;
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          // The closing edge doubles as the opening edge of the next period.
          if (CONT) begin
            cnt_d   = '0;
            hseen_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == LIMIT) begin
          period_d = MAX;
          if (fall)         high_d = cnt_inc;
          else if (hseen_q) high_d = shadow_q;
          else              high_d = MAX;
          ovf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hseen_q  <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sync_q   <= '0;
      d_q      <= 1'b0;
      warm_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hseen_q  <= hseen_d;
      period_q <= period_d;
      high_q   <= high_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      sync_q   <= sync_d;
      d_q      <= d_d;
      warm_q   <= warm_d;
    end
  end

  assign PERIOD    = period_q;
  assign HIGH_TIME = high_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: three instances (W=16, W=6, W=8) share the measured
// signal; expected results are queued when a measurement is launched.
module tb_period_meter;

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst, sig, cont;
  logic start16, start6, start8;
  logic [15:0] period16, high16;
  logic [5:0]  period6, high6;
  logic [7:0]  period8, high8;
  logic valid16, busy16, ovf16;
  logic valid6, busy6, ovf6;
  logic valid8, busy8, ovf8;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  bit gen_en = 1'b0;
  int gen_per = 2;
  int gen_high = 1;
  int gen_phase = 0;

  always #5 clk = ~clk;

  period_meter #(.W(16), .SYNC_STAGES(2)) dut16 (
    .CLK_in(clk), .RST(rst), .SIG_in(sig), .START(start16), .CONT(cont),
    .PERIOD(period16), .HIGH_TIME(high16), .VALID(valid16), .BUSY(busy16), .OVF(ovf16)
  );

  period_meter #(.W(6), .SYNC_STAGES(2)) dut6 (
    .CLK_in(clk), .RST(rst), .SIG_in(sig), .START(start6), .CONT(cont),
    .PERIOD(period6), .HIGH_TIME(high6), .VALID(valid6), .BUSY(busy6), .OVF(ovf6)
  );

  period_meter #(.W(8), .SYNC_STAGES(2)) dut8 (
    .CLK_in(clk), .RST(rst), .SIG_in(sig), .START(start8), .CONT(cont),
    .PERIOD(period8), .HIGH_TIME(high8), .VALID(valid8), .BUSY(busy8), .OVF(ovf8)
  );

  function automatic exp_t mk(input int p, input int h, input bit o);
    exp_t e;
    e.period = 16'(p);
    e.high   = 16'(h);
    e.ovf    = o;
    return e;
  endfunction

  // One clock cycle; the signal generator advances just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (gen_en) begin
      sig = (gen_phase < gen_high);
      gen_phase = (gen_phase + 1) % gen_per;
    end
  endtask

  task automatic set_gen(input int per, input int high);
    gen_per = per;
    gen_high = high;
    gen_phase = 0;
    gen_en = 1'b1;
  endtask

  task automatic quiesce();
    gen_en = 1'b0;
    sig = 1'b0;
    repeat (6) step();
  endtask

  task automatic wait_valid(input int which, input int budget, output bit got,
                            output logic [15:0] per, output logic [15:0] hi,
                            output logic o, output int cycles);
    got = 1'b0; per = '0; hi = '0; o = 1'b0; cycles = 0;
    while (!got && cycles < budget) begin
      step();
      cycles++;
      case (which)
        16: if (valid16) begin got = 1'b1; per = period16; hi = high16; o = ovf16; end
        6:  if (valid6)  begin got = 1'b1; per = {10'd0, period6}; hi = {10'd0, high6}; o = ovf6; end
        default: if (valid8) begin got = 1'b1; per = {8'd0, period8}; hi = {8'd0, high8}; o = ovf8; end
      endcase
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (period16 !== 16'd0) begin errors++; $display("[TB] FAIL reset_period: got %0d expected 0", period16); end
    checks++; if (high16 !== 16'd0) begin errors++; $display("[TB] FAIL reset_high: got %0d expected 0", high16); end
    checks++; if (valid16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy16); end
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf16); end
    rst = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_one_shot();
    bit got; logic [15:0] per, hi; logic o; int cyc; exp_t e; int extra;
    quiesce();
    exp_q.push_back(mk(2, 1, 1'b0));
    set_gen(2, 1);
    start16 = 1'b1; step(); start16 = 1'b0;
    checks++; if (busy16 !== 1'b1) begin errors++; $display("[TB] FAIL one_shot_busy_rise: got %b expected 1", busy16); end
    wait_valid(16, 50, got, per, hi, o, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL one_shot_valid: got no VALID expected one within 50 cycles"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL one_shot_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL one_shot_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL one_shot_ovf: got %b expected %b", o, e.ovf); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL one_shot_busy_fall: got %b expected 0", busy16); end
    end
    extra = 0;
    repeat (20) begin step(); if (valid16) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL one_shot_extra_valid: got %0d expected 0", extra); end
  endtask

  task automatic test_continuous();
    bit got; logic [15:0] per, hi; logic o; int cyc; exp_t e; int extra;
    quiesce();
    cont = 1'b1;
    set_gen(10, 5);
    start16 = 1'b1; step(); start16 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(mk(10, 5, 1'b0));
      wait_valid(16, 60, got, per, hi, o, cyc);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL cont_valid_%0d: got no VALID expected one", k); end
      else begin
        if (per !== e.period) begin errors++; $display("[TB] FAIL cont_period_%0d: got %0d expected %0d", k, per, e.period); end
        checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL cont_high_%0d: got %0d expected %0d", k, hi, e.high); end
        checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL cont_ovf_%0d: got %b expected %b", k, o, e.ovf); end
        if (k > 0) begin
          checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL cont_interval_%0d: got %0d expected 10", k, cyc); end
        end
        checks++;
        if (k < 4 && busy16 !== 1'b1) begin errors++; $display("[TB] FAIL cont_busy_%0d: got %b expected 1", k, busy16); end
        if (k == 4 && busy16 !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy_final: got %b expected 0", busy16); end
      end
      if (k == 3) cont = 1'b0;
    end
    extra = 0;
    repeat (30) begin step(); if (valid16) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL cont_after_stop: got %0d VALIDs expected 0", extra); end
  endtask

  task automatic test_asym_duty();
    bit got; logic [15:0] per, hi; logic o; int cyc; exp_t e;
    quiesce();
    exp_q.push_back(mk(100, 30, 1'b0));
    set_gen(100, 30);
    start16 = 1'b1; step(); start16 = 1'b0;
    wait_valid(16, 300, got, per, hi, o, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL asym16_valid: got no VALID expected one"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL asym16_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL asym16_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL asym16_ovf: got %b expected %b", o, e.ovf); end
    end
    quiesce();
    exp_q.push_back(mk(63, 30, 1'b1));
    set_gen(100, 30);
    start6 = 1'b1; step(); start6 = 1'b0;
    wait_valid(6, 200, got, per, hi, o, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL asym6_valid: got no VALID expected one"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL asym6_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL asym6_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL asym6_ovf: got %b expected %b", o, e.ovf); end
      checks++; if (busy6 !== 1'b0) begin errors++; $display("[TB] FAIL asym6_busy: got %b expected 0", busy6); end
    end
  endtask

  task automatic test_stuck();
    bit got; logic [15:0] per, hi; logic o; int cyc; exp_t e;
    quiesce();
    exp_q.push_back(mk(0, 0, 1'b1));
    start8 = 1'b1; step(); start8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL stuck_low_busy: got %b expected 1", busy8); end
    wait_valid(8, 400, got, per, hi, o, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL stuck_low_valid: got no VALID expected one"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL stuck_low_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL stuck_low_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL stuck_low_ovf: got %b expected %b", o, e.ovf); end
      checks++; if (cyc !== 255) begin errors++; $display("[TB] FAIL stuck_low_latency: got %0d expected 255", cyc); end
    end
    quiesce();
    exp_q.push_back(mk(255, 255, 1'b1));
    start8 = 1'b1; step(); start8 = 1'b0;
    sig = 1'b1;
    wait_valid(8, 400, got, per, hi, o, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL stuck_high_valid: got no VALID expected one"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL stuck_high_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL stuck_high_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL stuck_high_ovf: got %b expected %b", o, e.ovf); end
    end
    sig = 1'b0;
  endtask

  task automatic test_reset_mid_meas();
    bit got; logic [15:0] per, hi; logic o; int cyc; exp_t e; int extra;
    quiesce();
    set_gen(20, 10);
    start16 = 1'b1; step(); start16 = 1'b0;
    repeat (8) step();
    checks++; if (busy16 !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy16); end
    #1 rst = 1'b1;
    #1;
    checks++; if (period16 !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_period: got %0d expected 0", period16); end
    checks++; if (high16 !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_high: got %0d expected 0", high16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy16); end
    checks++; if (valid16 !== 1'b0 || ovf16 !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_flags: got valid=%b ovf=%b expected 0 0", valid16, ovf16); end
    gen_en = 1'b0;
    sig = 1'b1;
    start16 = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    extra = 0;
    repeat (40) begin step(); if (valid16) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL mid_spurious_valid: got %0d expected 0", extra); end
    sig = 1'b0;
    repeat (5) step();
    exp_q.push_back(mk(12, 4, 1'b0));
    set_gen(12, 4);
    wait_valid(16, 100, got, per, hi, o, cyc);
    start16 = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL mid_restart_valid: got no VALID expected one"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL mid_restart_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL mid_restart_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL mid_restart_ovf: got %b expected %b", o, e.ovf); end
    end
  endtask

  task automatic test_ignored_start();
    bit got; logic [15:0] per, hi; logic o; int cyc; exp_t e; int extra;
    quiesce();
    exp_q.push_back(mk(10, 3, 1'b0));
    set_gen(10, 3);
    start16 = 1'b1; step(); start16 = 1'b0;
    repeat (4) step();
    start16 = 1'b1; step(); start16 = 1'b0; step();
    start16 = 1'b1; step(); start16 = 1'b0;
    wait_valid(16, 50, got, per, hi, o, cyc);
    e = exp_q.pop_front();
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL ignored_valid: got no VALID expected one"); end
    else begin
      if (per !== e.period) begin errors++; $display("[TB] FAIL ignored_period: got %0d expected %0d", per, e.period); end
      checks++; if (hi !== e.high) begin errors++; $display("[TB] FAIL ignored_high: got %0d expected %0d", hi, e.high); end
      checks++; if (o !== e.ovf) begin errors++; $display("[TB] FAIL ignored_ovf: got %b expected %b", o, e.ovf); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("[TB] FAIL ignored_busy: got %b expected 0", busy16); end
    end
    extra = 0;
    repeat (20) begin step(); if (valid16) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL ignored_extra_valid: got %0d expected 0", extra); end
  endtask

  initial begin
    rst = 1'b1;
    sig = 1'b0;
    cont = 1'b0;
    start16 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    test_reset();
    test_one_shot();
    test_continuous();
    test_asym_duty();
    test_stuck();
    test_reset_mid_meas();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
